// File: rtl/float_combine.sv
// Rebuilds x = ((1-y)/(1+y)) * 2^n using external float add/sub/div cores.
// n waits in a FIFO until the quotient returns, then the exponent is repacked with saturation.
module float_combine #(
  parameter int C_DATA_WIDTH   = 32,
  parameter int C_FIFO_DEPTH   = 64,
  parameter int C_FLUSH_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    data_in_valid,
  input  logic [C_DATA_WIDTH-1:0] n_in,
  input  logic [C_DATA_WIDTH-1:0] y_in,
  output logic                    dataf_out_valid,
  output logic [C_DATA_WIDTH-1:0] dataf_out,
  output logic [C_DATA_WIDTH-1:0] add_a,
  output logic [C_DATA_WIDTH-1:0] add_b,
  output logic                    add_valid,
  input  logic [C_DATA_WIDTH-1:0] add_result,
  input  logic                    add_rdy,
  output logic [C_DATA_WIDTH-1:0] sub_a,
  output logic [C_DATA_WIDTH-1:0] sub_b,
  output logic                    sub_valid,
  input  logic [C_DATA_WIDTH-1:0] sub_result,
  input  logic                    sub_rdy,
  output logic [C_DATA_WIDTH-1:0] div_a,
  output logic [C_DATA_WIDTH-1:0] div_b,
  output logic                    div_valid,
  input  logic [C_DATA_WIDTH-1:0] div_result,
  input  logic                    div_rdy,
  output logic                    fifo_ovf,
  output logic                    fifo_udf,
  output logic [15:0]             sat_cnt,
  output logic                    flush_active
);

  localparam int AW = $clog2(C_FIFO_DEPTH);
  localparam int FW = $clog2(C_FLUSH_CYCLES + 1);
  localparam int SW = C_DATA_WIDTH + 2;
  localparam logic [C_DATA_WIDTH-1:0] FLOAT_ONE = C_DATA_WIDTH'(32'h3F800000);

  logic [C_DATA_WIDTH-1:0] mem [C_FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [AW:0]             count;
  logic [FW-1:0]           flush_cnt;

  logic                    full;
  logic                    empty;
  logic                    pop_req;
  logic                    do_pop;
  logic                    do_push;
  logic [C_DATA_WIDTH-1:0] n_head;
  logic                    q_sign;
  logic [7:0]              q_exp;
  logic [22:0]             q_frac;
  logic signed [SW-1:0]    exp_sum;
  logic [C_DATA_WIDTH-1:0] pack_word;
  logic                    pack_sat;

  assign add_a     = FLOAT_ONE;
  assign sub_a     = FLOAT_ONE;
  assign add_b     = y_in;
  assign sub_b     = y_in;
  assign add_valid = data_in_valid;
  assign sub_valid = data_in_valid;
  assign div_a     = sub_result;
  assign div_b     = add_result;
  assign div_valid = sub_rdy & add_rdy;

  assign flush_active = (flush_cnt != '0);

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    full    = (count == (AW+1)'(C_FIFO_DEPTH));
    empty   = (count == '0);
    pop_req = div_rdy & ~flush_active;
    do_pop  = pop_req & ~empty;
    do_push = data_in_valid & (~full | pop_req);
    n_head  = empty ? '0 : mem[rd_ptr];
  end

  always_comb begin
    q_sign    = div_result[C_DATA_WIDTH-1];
    q_exp     = div_result[30:23];
    q_frac    = div_result[22:0];
    exp_sum   = $signed({{2{n_head[C_DATA_WIDTH-1]}}, n_head})
              + $signed({{(SW-8){1'b0}}, q_exp});
    pack_word = {q_sign, 8'd0, q_frac};
    pack_sat  = 1'b0;
    if (q_exp == 8'hFF) begin
      pack_word = div_result;
    end else if (q_exp == 8'h00) begin
      pack_word = {q_sign, {(C_DATA_WIDTH-1){1'b0}}};
    end else if (exp_sum >= SW'(255)) begin
      pack_word = {q_sign, 8'hFF, 23'd0};
      pack_sat  = 1'b1;
    end else if (exp_sum <= SW'(0)) begin
      pack_word = {q_sign, {(C_DATA_WIDTH-1){1'b0}}};
      pack_sat  = 1'b1;
    end else begin
      pack_word = {q_sign, exp_sum[7:0], q_frac};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= n_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      flush_cnt       <= FW'(C_FLUSH_CYCLES);
      dataf_out_valid <= 1'b0;
      dataf_out       <= '0;
      fifo_ovf        <= 1'b0;
      fifo_udf        <= 1'b0;
      sat_cnt         <= '0;
    end else begin
      if (flush_active) flush_cnt <= flush_cnt - 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (data_in_valid & full & ~pop_req) fifo_ovf <= 1'b1;
      if (pop_req & empty) fifo_udf <= 1'b1;
      dataf_out_valid <= pop_req;
      if (pop_req) begin
        dataf_out <= pack_word;
        if (pack_sat && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_float_combine.sv
// Self-checking bench for float_combine: behavioural float cores plus a
// scoreboard of expected results filled when each input is driven.
module tb_float_combine;

  localparam int AS_LAT  = 11;
  localparam int DIV_LAT = 28;

  logic        clk;
  logic        reset;
  logic        data_in_valid;
  logic [31:0] n_in;
  logic [31:0] y_in;
  logic        dataf_out_valid;
  logic [31:0] dataf_out;
  logic [31:0] add_a, add_b, add_result;
  logic        add_valid, add_rdy;
  logic [31:0] sub_a, sub_b, sub_result;
  logic        sub_valid, sub_rdy;
  logic [31:0] div_a, div_b, div_result;
  logic        div_valid, div_rdy;
  logic        fifo_ovf, fifo_udf, flush_active;
  logic [15:0] sat_cnt;

  typedef struct { int due; logic [31:0] a; logic [31:0] s; } as_t;
  typedef struct { int due; logic [31:0] q; } dv_t;

  as_t         asq[$];
  dv_t         dq[$];
  logic [31:0] sb[$];
  int          cyc;
  bit          div_hold;
  logic [31:0] last_out;
  int          checks;
  int          errors;

  float_combine dut (
    .clk(clk), .reset(reset), .data_in_valid(data_in_valid), .n_in(n_in), .y_in(y_in),
    .dataf_out_valid(dataf_out_valid), .dataf_out(dataf_out),
    .add_a(add_a), .add_b(add_b), .add_valid(add_valid), .add_result(add_result), .add_rdy(add_rdy),
    .sub_a(sub_a), .sub_b(sub_b), .sub_valid(sub_valid), .sub_result(sub_result), .sub_rdy(sub_rdy),
    .div_a(div_a), .div_b(div_b), .div_valid(div_valid), .div_result(div_result), .div_rdy(div_rdy),
    .fifo_ovf(fifo_ovf), .fifo_udf(fifo_udf), .sat_cnt(sat_cnt), .flush_active(flush_active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic real to_real(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:23] == 8'h00) return 0.0;
    d = {b[31], {3'b000, b[30:23]} + 11'd896, b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] to_single(input real r);
    logic [63:0] d;
    logic [23:0] m;
    int          eu;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    if (d[62:52] == 11'h7FF) return {d[63], 8'hFF, (d[51:0] != 0) ? 23'h400000 : 23'h0};
    eu = int'(d[62:52]) - 896;
    if (eu >= 255) return {d[63], 8'hFF, 23'd0};
    if (eu <= 0) return {d[63], 31'd0};
    m = {1'b0, d[51:29]} + {23'd0, d[28]};
    if (m[23]) begin
      eu++;
      m = '0;
      if (eu >= 255) return {d[63], 8'hFF, 23'd0};
    end
    return {d[63], eu[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] div_model(input logic [31:0] a, input logic [31:0] b);
    if (to_real(b) == 0.0) return {a[31] ^ b[31], 8'hFF, 23'd0};
    return to_single(to_real(a) / to_real(b));
  endfunction

  function automatic logic [31:0] pack_model(input logic [31:0] q, input int n);
    longint sum;
    if (q[30:23] == 8'hFF) return q;
    if (q[30:23] == 8'h00) return {q[31], 31'd0};
    sum = longint'(n) + longint'(q[30:23]);
    if (sum >= 255) return {q[31], 8'hFF, 23'd0};
    if (sum <= 0) return {q[31], 31'd0};
    return {q[31], sum[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] expect_for(input int n, input logic [31:0] y);
    logic [31:0] q;
    q = div_model(to_single(1.0 - to_real(y)), to_single(1.0 + to_real(y)));
    return pack_model(q, n);
  endfunction

  // Core models: add/sub answer AS_LAT cycles after the strobe, the divider
  // DIV_LAT cycles later; a held divider buffers results and releases one per cycle.
  always @(posedge clk) begin
    dv_t d;
    if (add_valid)
      asq.push_back('{due: cyc + AS_LAT - 1, a: to_single(1.0 + to_real(add_b)), s: to_single(1.0 - to_real(sub_b))});
    if (asq.size() > 0 && asq[0].due == cyc) begin
      add_rdy    <= 1'b1;
      sub_rdy    <= 1'b1;
      add_result <= asq[0].a;
      sub_result <= asq[0].s;
      void'(asq.pop_front());
    end else begin
      add_rdy <= 1'b0;
      sub_rdy <= 1'b0;
    end
    if (div_valid)
      dq.push_back('{due: cyc + DIV_LAT - 1, q: div_model(div_a, div_b)});
    if (!div_hold && dq.size() > 0 && dq[0].due <= cyc) begin
      d = dq.pop_front();
      div_rdy    <= 1'b1;
      div_result <= d.q;
    end else begin
      div_rdy <= 1'b0;
    end
    cyc++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every result pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [31:0] e;
    if (dataf_out_valid) begin
      last_out = dataf_out;
      if (sb.size() == 0) begin
        check_output("spurious_valid", {31'd0, dataf_out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_output("dataf_out", dataf_out, e);
      end
    end
  end

  task automatic apply_stimulus(input int n, input logic [31:0] y, input bit zero_n);
    data_in_valid = 1'b1;
    n_in = 32'(n);
    y_in = y;
    sb.push_back(expect_for(zero_n ? 0 : n, y));
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    data_in_valid = 1'b0;
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int k;
    data_in_valid = 1'b0;
    k = 0;
    while (sb.size() > 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check_output("drain", sb.size(), 32'd0);
  endtask

  task automatic count_flush(output int len, output int pulses);
    len = 0;
    pulses = 0;
    while (flush_active && len < 200) begin
      len++;
      if (dataf_out_valid) pulses++;
      @(negedge clk);
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int len, pulses, lat;
    logic [31:0] yr;
    checks = 0;
    errors = 0;
    cyc = 0;
    div_hold = 1'b0;
    add_rdy = 1'b0; sub_rdy = 1'b0; div_rdy = 1'b0;
    add_result = '0; sub_result = '0; div_result = '0;
    data_in_valid = 1'b0; n_in = '0; y_in = '0;
    reset = 1'b1;

    repeat (3) @(negedge clk);
    check_output("rst_valid", {31'd0, dataf_out_valid}, 32'd0);
    check_output("rst_dataf_out", dataf_out, 32'd0);
    check_output("rst_sat_cnt", {16'd0, sat_cnt}, 32'd0);
    check_output("rst_flags", {30'd0, fifo_ovf, fifo_udf}, 32'd0);
    check_output("rst_flush_active", {31'd0, flush_active}, 32'd1);
    reset = 1'b0;
    count_flush(len, pulses);
    check_output("flush_len", len, 32'd64);

    $display("[TB] directed: n=3 y=0 and latency");
    apply_stimulus(3, 32'h0, 1'b0);
    data_in_valid = 1'b0;
    lat = 1;
    while (!dataf_out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check_output("latency", lat, 32'd40);
    @(negedge clk);
    check_output("single_pulse", {31'd0, dataf_out_valid}, 32'd0);
    check_output("n3_y0", last_out, 32'h41000000);

    $display("[TB] directed: y=1/3 and negative n");
    apply_stimulus(1, 32'h3EAAAAAB, 1'b0);
    wait_drain(100);
    check_output("third_near_one", {31'd0, (last_out >= 32'h3F7FFFFD && last_out <= 32'h3F800002)}, 32'd1);
    apply_stimulus(-2, 32'h0, 1'b0);
    wait_drain(100);
    check_output("nm2_y0", last_out, 32'h3E800000);

    $display("[TB] directed: saturation and inf passthrough");
    apply_stimulus(200, 32'h0, 1'b0);
    wait_drain(100);
    check_output("sat_hi", last_out, 32'h7F800000);
    check_output("sat_cnt_1", {16'd0, sat_cnt}, 32'd1);
    apply_stimulus(-127, 32'h0, 1'b0);
    wait_drain(100);
    check_output("sat_lo", last_out, 32'h00000000);
    check_output("sat_cnt_2", {16'd0, sat_cnt}, 32'd2);
    apply_stimulus(5, 32'hBF800000, 1'b0);
    wait_drain(100);
    check_output("inf_pass", last_out, 32'h7F800000);
    check_output("sat_cnt_hold", {16'd0, sat_cnt}, 32'd2);

    $display("[TB] random back-to-back stream");
    for (int i = 0; i < 200; i++) begin
      yr = to_single((real'($urandom_range(0, 1798)) - 899.0) / 1000.0);
      apply_stimulus(int'($urandom_range(0, 40)) - 20, yr, 1'b0);
    end
    wait_drain(200);
    check_output("rand_flags", {30'd0, fifo_ovf, fifo_udf}, 32'd0);
    check_output("rand_sat_cnt", {16'd0, sat_cnt}, 32'd2);

    $display("[TB] FIFO overflow then underflow");
    div_hold = 1'b1;
    for (int i = 0; i < 64; i++) apply_stimulus((i % 10) - 5, 32'h0, 1'b0);
    check_output("no_ovf_at_64", {31'd0, fifo_ovf}, 32'd0);
    apply_stimulus(7, 32'h0, 1'b1);
    check_output("ovf_at_65", {31'd0, fifo_ovf}, 32'd1);
    check_output("no_udf_yet", {31'd0, fifo_udf}, 32'd0);
    idle(50);
    div_hold = 1'b0;
    wait_drain(200);
    check_output("udf_set", {31'd0, fifo_udf}, 32'd1);
    check_output("udf_n0_result", last_out, 32'h3F800000);

    $display("[TB] reset with results in flight");
    for (int i = 0; i < 10; i++) apply_stimulus(i, 32'h0, 1'b0);
    idle(5);
    reset = 1'b1;
    sb.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    count_flush(len, pulses);
    check_output("flush2_len", len, 32'd64);
    check_output("flush2_pulses", pulses, 32'd0);
    check_output("flush2_flags", {30'd0, fifo_ovf, fifo_udf}, 32'd0);
    apply_stimulus(3, 32'h0, 1'b0);
    wait_drain(100);
    check_output("post_flush", last_out, 32'h41000000);
    check_output("post_flush_udf", {31'd0, fifo_udf}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/float_combine.md
Name: float_combine

Overview:
- Inverse of the log-domain float split in the his_eq path: takes a signed integer exponent n and a float y, and rebuilds x = 1.m * 2^n, where 1.m = (1-y)/(1+y).
- Drives the shared external float add/sub/div cores.
- Aligns n with the quotient through an internal FIFO.
- Packs the IEEE-754 single result with saturation, then feeds the equalizer's inverse-mapping stage.

Parameters:
- C_DATA_WIDTH, 32, data/float width (single precision only).
- C_FIFO_DEPTH, 64, n-alignment FIFO depth (power of 2, must exceed add/sub+div latency).
- C_FLUSH_CYCLES, 64, cycles after reset during which div_rdy is ignored.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- data_in_valid  in  1  n_in/y_in valid.
- n_in  in  C_DATA_WIDTH  signed integer exponent n.
- y_in  in  C_DATA_WIDTH  float y.
- dataf_out_valid  out  1  result valid pulse.
- dataf_out  out  C_DATA_WIDTH  float result x.
- add_a/add_b  out  C_DATA_WIDTH  adder operands.
- add_valid  out  1  adder strobe.
- add_result  in  C_DATA_WIDTH  adder result.
- add_rdy  in  1  adder result valid.
- sub_a/sub_b  out  C_DATA_WIDTH  subtractor operands.
- sub_valid  out  1  subtractor strobe.
- sub_result  in  C_DATA_WIDTH  subtractor result.
- sub_rdy  in  1  subtractor result valid.
- div_a/div_b  out  C_DATA_WIDTH  divider operands.
- div_valid  out  1  divider strobe.
- div_result  in  C_DATA_WIDTH  divider result.
- div_rdy  in  1  divider result valid.
- fifo_ovf  out  1  sticky: push while full.
- fifo_udf  out  1  sticky: pop while empty.
- sat_cnt  out  16  saturating count of clamped results.
- flush_active  out  1  high during post-reset flush window.

Behaviour:
- One clock domain: clk. Reset is synchronous, active-high.
- Reset values: all outputs 0; FIFO pointers/count 0; flush counter loaded to C_FLUSH_CYCLES; flush_active=1 in the cycle after reset.
- Combinational issue, same cycle as input:
  - sub_a=add_a=32'h3F800000; sub_b=add_b=y_in.
  - sub_valid=add_valid=data_in_valid.
  - div_a=sub_result; div_b=add_result; div_valid=sub_rdy&add_rdy.
- FIFO push: n_in is pushed on data_in_valid. If full and no pop, the write is dropped and fifo_ovf is set.
- Simultaneous push+pop: always allowed, including when full (count unchanged) or empty (pushed word is not the popped word, so empty+pop flags underflow).
- Flush window:
  - A counter decrements each cycle while nonzero; flush_active=(counter!=0).
  - While flush_active, div_rdy is ignored: no pop, no output. This discards in-flight core results after reset mid-operation.
  - data_in_valid is still accepted during the window.
- Pop: on div_rdy & ~flush_active, pop the FIFO head as n. If empty: n=0, fifo_udf set, result still produced.
- Pack (registered, dataf_out_valid one cycle after the accepted div_rdy). Let s=div_result[31], e=div_result[30:23], f=div_result[22:0], sum = sign-extended n + e, computed with at least 34 bits.
  - e==255: output div_result unchanged (inf/NaN, e.g. y=-1). No saturation count.
  - e==0: output {s,31'b0}.
  - sum>=255: output {s,8'hFF,23'b0}; sat_cnt++.
  - sum<=0: output {s,31'b0}; sat_cnt++ (no denormals).
  - otherwise: output {s,sum[7:0],f}.
- sat_cnt holds at 16'hFFFF.
- dataf_out holds its value between valids; dataf_out_valid is a single-cycle pulse per accepted div_rdy.
- Results come out in input order; one input gives exactly one output (except flushed or dropped).
- Throughput: one input per cycle, provided the FIFO does not overflow.

Test Plan:
1. Core models with add/sub latency 11 and div latency 28. After the flush window, n=3, y=0 -> quotient 0x3F800000 -> dataf_out=0x41000000, one valid pulse, latency = core latency + 1.
2. n=1, y=0x3EAAAAAB (1/3) -> quotient ~0x3F000000 -> dataf_out ~0x3F800000. Then n=-2, y=0 -> 0x3E800000.
3. n=200, y=0 -> 0x7F800000 and sat_cnt=1. Then n=-127, y=0 -> 0x00000000 and sat_cnt=2. Then y=0xBF800000 (-1), quotient +inf -> 0x7F800000 passed through, sat_cnt unchanged.
4. Hold div_rdy low and push 65 inputs -> fifo_ovf=1 on the 65th, first 64 retained. Then one div_rdy with an empty FIFO after draining -> fifo_udf=1, output uses n=0.
5. 200 back-to-back random inputs, n in [-20,20], y in (-0.9,0.9) -> outputs match the golden model, in order, with no flags set.
6. Assert reset with 10 results in flight. Core models keep emitting -> no dataf_out_valid during flush, flush_active deasserts after 64 cycles, FIFO empty, fifo_udf=0, the next input produces a correct result.
